// File: rtl/udptx_pkg.sv
// UDP transmit framer shared types and constants.
// Control word encoding and header sizing live here.
package udptx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_PAY,
    S_CTRL
  } state_t;

  localparam logic [1:0] CTRL_START = 2'd0;
  localparam logic [1:0] CTRL_STOP  = 2'd1;
  localparam logic [1:0] CTRL_SEQ   = 2'd2;
  localparam logic [1:0] CTRL_NONE  = 2'd3;

  localparam logic [15:0] CTRL_LEN  = 16'd10;
  localparam logic [15:0] HDR_BYTES = 16'd8;

  // A zero sequence number is indistinguishable from start.
  function automatic logic [15:0] ctrl_word(
    input logic [1:0]  kind,
    input logic [14:0] seq
  );
    logic [15:0] w;
    w = 16'h0000;
    unique case (1'b1)
      kind == CTRL_START:
        w = 16'h0000;
      kind == CTRL_STOP:
        w = 16'h0001;
      kind == CTRL_SEQ && seq != 15'd0:
        w = {seq, 1'b0};
      default:
        w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/udptx_buf.sv
// Payload buffer: simple dual-port RAM,
// one write port and a registered read port.
module udptx_buf #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/udptx_framer.sv
// UDP transmit framer: buffers payload, emits header
// with checksum ahead of it, or a one-word control segment.
module udptx_framer
  import udptx_pkg::*;
#(
  parameter logic [15:0] SRC_PORT = 16'h1388,
  parameter int          BUF_AW   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dstport,
  input  logic        ctrl_req,
  input  logic [1:0]  ctrl_kind,
  input  logic [14:0] ctrl_seq,
  output logic        ctrl_ack,
  input  logic        data_sof,
  input  logic        data_eof,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  output logic        data_ready,
  output logic        udpsof,
  output logic        udpeof,
  output logic        udpvalidout,
  output logic [15:0] udpdataout,
  input  logic        udpready,
  output logic        busy,
  output logic        err_overflow
);

  localparam int CW = BUF_AW + 1;
  localparam logic [CW-1:0] LAST =
    CW'((1 << BUF_AW) - 1);

  state_t            state;
  logic              mode_ctrl;
  logic [15:0]       dport;
  logic [15:0]       sum;
  logic [15:0]       cword;
  logic [CW-1:0]     count;
  logic [BUF_AW-1:0] rd_addr;

  logic              idle;
  logic              take_ctrl;
  logic              acc;
  logic              xfer;
  logic              adv;
  logic              last_rd;
  logic              we;
  logic [BUF_AW-1:0] waddr;
  logic [BUF_AW-1:0] raddr;
  logic [15:0]       q;
  logic [15:0]       len;
  logic [15:0]       cksum;
  logic [15:0]       cw_new;

  assign idle = state == S_IDLE;
  // The ack register blocks recapture while the requester reacts.
  assign take_ctrl = idle && ctrl_req && !ctrl_ack;
  assign data_ready = (idle && !ctrl_req)
                   || state == S_LOAD;
  assign acc  = data_valid && data_ready;
  assign xfer = udpvalidout && udpready;
  assign busy = !idle;

  assign len = mode_ctrl ? CTRL_LEN
             : HDR_BYTES + 16'({count, 1'b0});
  assign cksum = ~(SRC_PORT + dport + len + sum);
  assign cw_new = ctrl_word(ctrl_kind, ctrl_seq);

  assign we = acc && ((idle && data_sof)
           || (state == S_LOAD && !data_sof));
  assign waddr = idle ? '0 : count[BUF_AW-1:0];

  // q always holds mem[rd_addr]; look one ahead on a transfer.
  assign adv = xfer
    && ((state == S_HDR3 && !mode_ctrl)
     || (state == S_PAY && !udpeof));
  assign raddr = adv ? rd_addr + 1'b1 : rd_addr;
  assign last_rd = {1'b0, rd_addr} == count - 1'b1;

  udptx_buf #(
    .AW(BUF_AW)
  ) u_buf (
    .clock(clock),
    .we   (we),
    .waddr(waddr),
    .wdata(data_in),
    .raddr(raddr),
    .rdata(q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      mode_ctrl    <= 1'b0;
      dport        <= '0;
      sum          <= '0;
      cword        <= '0;
      count        <= '0;
      rd_addr      <= '0;
      ctrl_ack     <= 1'b0;
      err_overflow <= 1'b0;
      udpsof       <= 1'b0;
      udpeof       <= 1'b0;
      udpvalidout  <= 1'b0;
      udpdataout   <= '0;
    end else begin
      ctrl_ack     <= 1'b0;
      err_overflow <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take_ctrl) begin
            ctrl_ack <= 1'b1;
            if (ctrl_kind != CTRL_NONE) begin
              mode_ctrl   <= 1'b1;
              dport       <= dstport;
              cword       <= cw_new;
              sum         <= cw_new;
              state       <= S_HDR0;
              udpvalidout <= 1'b1;
              udpsof      <= 1'b1;
              udpdataout  <= SRC_PORT;
              rd_addr     <= '0;
            end
          end else if (acc && data_sof) begin
            mode_ctrl <= 1'b0;
            dport     <= dstport;
            sum       <= data_in;
            count     <= CW'(1);
            if (data_eof) begin
              state       <= S_HDR0;
              udpvalidout <= 1'b1;
              udpsof      <= 1'b1;
              udpdataout  <= SRC_PORT;
              rd_addr     <= '0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (acc) begin
            if (data_sof) begin
              err_overflow <= 1'b1;
              state        <= S_IDLE;
            end else begin
              sum   <= sum + data_in;
              count <= count + 1'b1;
              if (data_eof) begin
                state       <= S_HDR0;
                udpvalidout <= 1'b1;
                udpsof      <= 1'b1;
                udpdataout  <= SRC_PORT;
                rd_addr     <= '0;
              end else if (count == LAST) begin
                err_overflow <= 1'b1;
                state        <= S_IDLE;
              end
            end
          end
        end
        S_HDR0: begin
          if (xfer) begin
            udpsof     <= 1'b0;
            udpdataout <= dport;
            state      <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer) begin
            udpdataout <= len;
            state      <= S_HDR2;
          end
        end
        S_HDR2: begin
          if (xfer) begin
            udpdataout <= cksum;
            state      <= S_HDR3;
          end
        end
        S_HDR3: begin
          if (xfer) begin
            if (mode_ctrl) begin
              udpdataout <= cword;
              udpeof     <= 1'b1;
              state      <= S_CTRL;
            end else begin
              udpdataout <= q;
              udpeof     <= last_rd;
              rd_addr    <= rd_addr + 1'b1;
              state      <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (xfer) begin
            if (udpeof) begin
              udpvalidout <= 1'b0;
              udpeof      <= 1'b0;
              state       <= S_IDLE;
            end else begin
              udpdataout <= q;
              udpeof     <= last_rd;
              rd_addr    <= rd_addr + 1'b1;
            end
          end
        end
        S_CTRL: begin
          if (xfer) begin
            udpvalidout <= 1'b0;
            udpeof      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udptx_framer.sv
// Scoreboard bench for udptx_framer: directed segments,
// monitor pops expected words on every output transfer.
module tb_udptx_framer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dstport = 16'h1389;
  logic        ctrl_req = 1'b0;
  logic [1:0]  ctrl_kind = 2'd0;
  logic [14:0] ctrl_seq = 15'd0;
  logic        ctrl_ack;
  logic        data_sof = 1'b0;
  logic        data_eof = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        data_ready;
  logic        udpsof;
  logic        udpeof;
  logic        udpvalidout;
  logic [15:0] udpdataout;
  logic        udpready = 1'b1;
  logic        busy;
  logic        err_overflow;

  udptx_framer dut (
    .clock       (clock),
    .reset       (reset),
    .dstport     (dstport),
    .ctrl_req    (ctrl_req),
    .ctrl_kind   (ctrl_kind),
    .ctrl_seq    (ctrl_seq),
    .ctrl_ack    (ctrl_ack),
    .data_sof    (data_sof),
    .data_eof    (data_eof),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .data_ready  (data_ready),
    .udpsof      (udpsof),
    .udpeof      (udpeof),
    .udpvalidout (udpvalidout),
    .udpdataout  (udpdataout),
    .udpready    (udpready),
    .busy        (busy),
    .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          fails = 0;
  int          ack_cnt = 0;
  int          err_cnt = 0;
  int          a0;
  int          e0;
  bit          rand_rdy = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_w;
  logic [17:0] held;
  logic        stalled = 1'b0;
  logic [15:0] acc = 16'h0000;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input logic s, input logic e,
                      input logic [15:0] d);
    exp_q.push_back({s, e, d});
  endtask

  task automatic push_hdr(input logic [15:0] dst,
                          input logic [15:0] len,
                          input logic [15:0] ck);
    push(1'b1, 1'b0, 16'h1388);
    push(1'b0, 1'b0, dst);
    push(1'b0, 1'b0, len);
    push(1'b0, 1'b0, ck);
  endtask

  always @(posedge clock) begin
    #1;
    udpready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clock) begin
    if (ctrl_ack) ack_cnt++;
    if (err_overflow) err_cnt++;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (stalled)
        check("stall_hold",
              {13'd0, udpvalidout, udpsof, udpeof, udpdataout},
              {13'd0, 1'b1, held});
      if (udpvalidout && udpready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_word: got %h want none",
                   {udpsof, udpeof, udpdataout});
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {14'd0, udpsof, udpeof, udpdataout},
                {14'd0, exp_w});
        end
        acc = udpsof ? udpdataout : acc + udpdataout;
        if (udpeof) check("seg_sum", {16'd0, acc}, 32'h0000ffff);
      end
      stalled = udpvalidout && !udpready;
      held = {udpsof, udpeof, udpdataout};
    end
  end

  task automatic send_ctrl(input logic [1:0] k,
                           input logic [14:0] s);
    bit got;
    got = 1'b0;
    ctrl_req = 1'b1;
    ctrl_kind = k;
    ctrl_seq = s;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (ctrl_ack) begin
        got = 1'b1;
        ctrl_req = 1'b0;
      end
    end
    if (!got) begin
      vectors++;
      fails++;
      ctrl_req = 1'b0;
      $display("FAIL ctrl_ack_timeout: got none want ack");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic put_word(input logic s, input logic e,
                          input logic [15:0] d);
    bit got;
    got = 1'b0;
    data_valid = 1'b1;
    data_sof = s;
    data_eof = e;
    data_in = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (data_ready) got = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    if (!got) begin
      vectors++;
      fails++;
      $display("FAIL data_ready_timeout: got 0 want 1");
    end
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    data_sof = 1'b0;
    data_eof = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6000 && (exp_q.size() != 0 || busy); i++)
      @(posedge clock);
    #1;
    if (exp_q.size() != 0 || busy) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout: got %0d left want 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic seg693();
    push_hdr(16'h1389, 16'h0572, 16'h2ADA);
    for (int i = 0; i < 693; i++)
      push(1'b0, i == 692, 16'(i));
    for (int i = 0; i < 693; i++)
      put_word(i == 0, i == 692, 16'(i));
    drain();
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge clock);
    #1;
    check("reset_flags",
          {26'd0, udpvalidout, udpsof, udpeof,
           ctrl_ack, err_overflow, busy}, 32'd0);
    check("reset_data", {16'd0, udpdataout}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    a0 = ack_cnt;
    push_hdr(16'h1389, 16'h000A, 16'hD8E4);
    push(1'b0, 1'b1, 16'h0000);
    send_ctrl(2'd0, 15'd0);
    drain();
    check("ack_start", ack_cnt - a0, 1);

    a0 = ack_cnt;
    push_hdr(16'h1389, 16'h000A, 16'hD8DA);
    push(1'b0, 1'b1, 16'h000A);
    send_ctrl(2'd2, 15'd5);
    drain();
    check("ack_seq", ack_cnt - a0, 1);

    seg693();

    rand_rdy = 1'b1;
    seg693();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    e0 = err_cnt;
    for (int i = 0; i < 1025; i++)
      put_word(i == 0, 1'b0, 16'(16'h4000 + i));
    repeat (3) @(posedge clock);
    #1;
    check("overflow_pulse", err_cnt - e0, 1);
    check("overflow_idle", {31'd0, busy}, 32'd0);
    check("overflow_novalid", {31'd0, udpvalidout}, 32'd0);
    push_hdr(16'h1389, 16'h000A, 16'h19F5);
    push(1'b0, 1'b1, 16'hBEEF);
    put_word(1'b1, 1'b1, 16'hBEEF);
    drain();

    a0 = ack_cnt;
    push_hdr(16'h1389, 16'h000A, 16'hD8E3);
    push(1'b0, 1'b1, 16'h0001);
    push_hdr(16'h1389, 16'h000A, 16'hD8DF);
    push(1'b0, 1'b1, 16'h0005);
    ctrl_req = 1'b1;
    ctrl_kind = 2'd1;
    data_valid = 1'b1;
    data_sof = 1'b1;
    data_eof = 1'b1;
    data_in = 16'h0005;
    #1;
    check("collide_ready", {31'd0, data_ready}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (ctrl_ack) ctrl_req = 1'b0;
      #0;
      if (data_ready && !ctrl_req) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      fails++;
      ctrl_req = 1'b0;
      $display("FAIL collide_accept_timeout: got none want accept");
    end
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    data_sof = 1'b0;
    data_eof = 1'b0;
    drain();
    check("ack_collide", ack_cnt - a0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
